// File: rtl/stack_ctrl_unit.sv
// Stack control unit: runs one command per req/ack and drives the PO alpha/beta pulses; ack at +3 cycles for PUSH, +2 otherwise.
// No downstream backpressure; upstream holds req/op until ack. Optional sticky error flag via `STACK_STICKY_ERR_EN.
module stack_ctrl_unit #(
  parameter int DEPTH = 1024,
  parameter int CW    = 11
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req,
  input  logic [1:0]    op,
  output logic          ack,
  output logic          err,
  output logic          busy,
  output logic [CW-1:0] count,
  output logic          err_sticky,
  output logic          beta_datain,
  output logic          beta_mem,
  output logic          alpha_k_mem1,
  output logic          beta_hd,
  output logic [2:0]    alpha_alu2,
  output logic          beta_dataout
);

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_TOP   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [2:0] ALU_INC  = 3'b000;
  localparam logic [2:0] ALU_DEC  = 3'b001;
  localparam logic [2:0] ALU_ZERO = 3'b010;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PUSH_LD = 3'd1,
    S_PUSH_WR = 3'd2,
    S_RD      = 3'd3,
    S_CLR     = 3'd4,
    S_ERR     = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [1:0] op_q;
  logic [1:0] op_eff;
  logic       is_full;
  logic       is_empty;

  assign is_full  = (count == FULL_COUNT);
  assign is_empty = (count == '0);

  // While leaving IDLE the latched op is not yet valid, so decode from the live input.
  assign op_eff = (state == S_IDLE) ? op : op_q;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          case (op)
            OP_PUSH:  nxt = is_full  ? S_ERR : S_PUSH_LD;
            OP_POP,
            OP_TOP:   nxt = is_empty ? S_ERR : S_RD;
            default:  nxt = S_CLR;
          endcase
        end
      end
      S_PUSH_LD: nxt = S_PUSH_WR;
      S_PUSH_WR,
      S_RD,
      S_CLR,
      S_ERR:     nxt = S_DONE;
      S_DONE:    nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      op_q         <= OP_PUSH;
      count        <= '0;
      ack          <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
      beta_datain  <= 1'b0;
      beta_mem     <= 1'b0;
      alpha_k_mem1 <= 1'b0;
      beta_hd      <= 1'b0;
      alpha_alu2   <= ALU_INC;
      beta_dataout <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && req) begin
        op_q <= op;
      end

      case (state)
        S_PUSH_WR: count <= count + CW'(1);
        S_RD:      if (op_q == OP_POP) count <= count - CW'(1);
        S_CLR:     count <= '0;
        default:   count <= count;
      endcase

      busy         <= (nxt != S_IDLE);
      ack          <= (nxt == S_DONE);
      err          <= (nxt == S_DONE) && (state == S_ERR);
      beta_datain  <= (nxt == S_PUSH_LD);
      beta_mem     <= (nxt == S_PUSH_WR);
      alpha_k_mem1 <= (nxt == S_RD);
      beta_dataout <= (nxt == S_RD);
      beta_hd      <= (nxt == S_PUSH_WR) || (nxt == S_CLR) ||
                      ((nxt == S_RD) && (op_eff == OP_POP));
      if ((nxt == S_RD) && (op_eff == OP_POP)) begin
        alpha_alu2 <= ALU_DEC;
      end else if (nxt == S_CLR) begin
        alpha_alu2 <= ALU_ZERO;
      end else begin
        alpha_alu2 <= ALU_INC;
      end
    end
  end

`ifdef STACK_STICKY_ERR_EN
  logic sticky_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sticky_q <= 1'b0;
    end else if (nxt == S_CLR) begin
      sticky_q <= 1'b0;
    end else if ((nxt == S_DONE) && (state == S_ERR)) begin
      sticky_q <= 1'b1;
    end
  end

  assign err_sticky = sticky_q;
`else
  assign err_sticky = 1'b0;
`endif

endmodule
